// File: rtl/pwm_ctrl_pkg.sv
// Shared types for the PWM profile scheduler: FSM states, profile entry layout
// and the reserved frequency code.
package pwm_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } sched_state_t;

    // Widest dwell field the table can hold; DWELL_BITS must not exceed this.
    localparam int DWELL_W_MAX = 16;

    typedef struct packed {
        logic [3:0]             duty;
        logic [1:0]             freq;
        logic [DWELL_W_MAX-1:0] dwell;
    } profile_entry_t;

    localparam logic [1:0] FREQ_ILLEGAL = 2'd0;

endpackage

// File: rtl/pwm_profile_table.sv
// Profile register file: one write port, two combinational read ports (entry 0
// and an addressed entry), per-entry valid bits and illegal-write detection.
module pwm_profile_table
    import pwm_ctrl_pkg::*;
#(
    parameter int N_STEPS    = 4,
    parameter int DWELL_BITS = 8,
    localparam int IDX_W     = $clog2(N_STEPS)
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  wr_en,
    input  logic [IDX_W-1:0]      wr_addr,
    input  logic [3:0]            wr_duty,
    input  logic [1:0]            wr_freq,
    input  logic [DWELL_BITS-1:0] wr_dwell,
    input  logic [IDX_W-1:0]      rd_addr,
    output profile_entry_t        rd_entry,
    output logic                  rd_valid,
    output profile_entry_t        rd0_entry,
    output logic                  rd0_valid,
    output logic                  wr_illegal
);

    profile_entry_t       entries [N_STEPS];
    logic [N_STEPS-1:0]   valid;
    profile_entry_t       wr_word;
    logic                 wr_legal;

    assign wr_legal   = wr_en && (wr_freq != FREQ_ILLEGAL);
    assign wr_illegal = wr_en && (wr_freq == FREQ_ILLEGAL);

    always_comb begin
        wr_word       = '0;
        wr_word.duty  = wr_duty;
        wr_word.freq  = wr_freq;
        wr_word.dwell[DWELL_BITS-1:0] = wr_dwell;
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            valid <= '0;
        end else if (wr_legal) begin
            valid[wr_addr] <= 1'b1;
        end
    end

    // Data needs no reset: it is never used while its valid bit is clear.
    always_ff @(posedge Clk) begin
        if (wr_legal) begin
            entries[wr_addr] <= wr_word;
        end
    end

    assign rd_entry  = entries[rd_addr];
    assign rd_valid  = valid[rd_addr];
    assign rd0_entry = entries[0];
    assign rd0_valid = valid[0];

endmodule

// File: rtl/pwm_profile_scheduler.sv
// Steps the PWM generator through the programmed profile, switching settings
// only on period boundaries; owns the generator's enable, duty and frequency.
module pwm_profile_scheduler
    import pwm_ctrl_pkg::*;
#(
    parameter int N_STEPS    = 4,
    parameter int DWELL_BITS = 8,
    parameter int LOOP       = 0,
    localparam int IDX_W     = $clog2(N_STEPS)
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  wr_en,
    input  logic [IDX_W-1:0]      wr_addr,
    input  logic [3:0]            wr_duty,
    input  logic [1:0]            wr_freq,
    input  logic [DWELL_BITS-1:0] wr_dwell,
    input  logic                  period_done,
    output logic                  pwm_en,
    output logic [3:0]            pwm_duty,
    output logic [1:0]            pwm_freq,
    output logic                  busy,
    output logic [IDX_W-1:0]      step_idx,
    output logic                  seq_done,
    output logic                  err
);

    sched_state_t          state_q, state_d;
    logic [DWELL_BITS-1:0] dwell_q, dwell_d;
    logic                  en_d;
    logic [3:0]            duty_d;
    logic [1:0]            freq_d;
    logic [IDX_W-1:0]      step_d;
    logic                  seq_done_d;
    logic                  start_err;
    logic                  err_d;
    logic                  busy_d;

    profile_entry_t        rd_entry, rd0_entry;
    logic                  rd_valid, rd0_valid;
    logic                  wr_illegal;
    logic [IDX_W:0]        next_idx;
    logic                  at_end;
    logic [DWELL_BITS-1:0] rd_dwell_ld, rd0_dwell_ld;

    pwm_profile_table #(
        .N_STEPS    (N_STEPS),
        .DWELL_BITS (DWELL_BITS)
    ) u_table (
        .Clk        (Clk),
        .Rst        (Rst),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_duty    (wr_duty),
        .wr_freq    (wr_freq),
        .wr_dwell   (wr_dwell),
        .rd_addr    (next_idx[IDX_W-1:0]),
        .rd_entry   (rd_entry),
        .rd_valid   (rd_valid),
        .rd0_entry  (rd0_entry),
        .rd0_valid  (rd0_valid),
        .wr_illegal (wr_illegal)
    );

    assign next_idx = {1'b0, step_idx} + 1'b1;
    assign at_end   = (next_idx == (IDX_W+1)'(N_STEPS)) || !rd_valid;

    // A zero dwell counts as one period; the full-width test covers the unused upper bits.
    assign rd_dwell_ld  = (rd_entry.dwell == '0)  ? DWELL_BITS'(1) : rd_entry.dwell[DWELL_BITS-1:0];
    assign rd0_dwell_ld = (rd0_entry.dwell == '0) ? DWELL_BITS'(1) : rd0_entry.dwell[DWELL_BITS-1:0];

    always_comb begin
        state_d    = state_q;
        dwell_d    = dwell_q;
        en_d       = pwm_en;
        duty_d     = pwm_duty;
        freq_d     = pwm_freq;
        step_d     = step_idx;
        seq_done_d = 1'b0;
        start_err  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (rd0_valid) begin
                        duty_d  = rd0_entry.duty;
                        freq_d  = rd0_entry.freq;
                        dwell_d = rd0_dwell_ld;
                        step_d  = '0;
                        en_d    = 1'b1;
                        state_d = S_RUN;
                    end else begin
                        start_err = 1'b1;
                    end
                end
            end

            S_RUN: begin
                if (stop) begin
                    if (period_done) begin
                        en_d    = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end else if (period_done) begin
                    if (dwell_q > DWELL_BITS'(1)) begin
                        dwell_d = dwell_q - DWELL_BITS'(1);
                    end else if (!at_end) begin
                        duty_d  = rd_entry.duty;
                        freq_d  = rd_entry.freq;
                        dwell_d = rd_dwell_ld;
                        step_d  = next_idx[IDX_W-1:0];
                    end else if (LOOP != 0) begin
                        duty_d  = rd0_entry.duty;
                        freq_d  = rd0_entry.freq;
                        dwell_d = rd0_dwell_ld;
                        step_d  = '0;
                    end else begin
                        en_d       = 1'b0;
                        seq_done_d = 1'b1;
                        state_d    = S_IDLE;
                    end
                end
            end

            S_DRAIN: begin
                if (period_done) begin
                    en_d    = 1'b0;
                    state_d = S_IDLE;
                end
            end

            default: begin
                en_d    = 1'b0;
                state_d = S_IDLE;
            end
        endcase

        err_d  = wr_illegal | start_err;
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_q  <= S_IDLE;
            dwell_q  <= '0;
            pwm_en   <= 1'b0;
            pwm_duty <= 4'd0;
            pwm_freq <= 2'd1;
            step_idx <= '0;
            busy     <= 1'b0;
            seq_done <= 1'b0;
            err      <= 1'b0;
        end else begin
            state_q  <= state_d;
            dwell_q  <= dwell_d;
            pwm_en   <= en_d;
            pwm_duty <= duty_d;
            pwm_freq <= freq_d;
            step_idx <= step_d;
            busy     <= busy_d;
            seq_done <= seq_done_d;
            err      <= err_d;
        end
    end

endmodule

// File: tb/tb_pwm_profile_scheduler.sv
// Directed bench: two scheduler instances (LOOP=0 and LOOP=1) share stimulus;
// each vector names which instance's outputs it checks.
module tb_pwm_profile_scheduler;

    logic       Clk;
    logic       Rst;
    logic       start, stop, wr_en, period_done;
    logic [1:0] wr_addr;
    logic [3:0] wr_duty;
    logic [1:0] wr_freq;
    logic [7:0] wr_dwell;

    logic       a_en, a_busy, a_sd, a_err;
    logic [3:0] a_duty;
    logic [1:0] a_freq, a_step;
    logic       b_en, b_busy, b_sd, b_err;
    logic [3:0] b_duty;
    logic [1:0] b_freq, b_step;

    int checks = 0;
    int errors = 0;
    int vec_no = 0;

    typedef struct packed {
        logic       rst_n, start, stop, pd, wr_en;
        logic [1:0] wr_addr;
        logic [3:0] wr_duty;
        logic [1:0] wr_freq;
        logic [7:0] wr_dwell;
        logic       sel;
        logic       e_en;
        logic [3:0] e_duty;
        logic [1:0] e_freq;
        logic       e_busy;
        logic [1:0] e_step;
        logic       e_sd;
        logic       e_err;
    } vec_t;

    vec_t vecs[$];

    pwm_profile_scheduler #(.N_STEPS(4), .DWELL_BITS(8), .LOOP(0)) dut (
        .Clk(Clk), .Rst(Rst), .start(start), .stop(stop), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_duty(wr_duty), .wr_freq(wr_freq), .wr_dwell(wr_dwell),
        .period_done(period_done), .pwm_en(a_en), .pwm_duty(a_duty), .pwm_freq(a_freq),
        .busy(a_busy), .step_idx(a_step), .seq_done(a_sd), .err(a_err)
    );

    pwm_profile_scheduler #(.N_STEPS(4), .DWELL_BITS(8), .LOOP(1)) dut_loop (
        .Clk(Clk), .Rst(Rst), .start(start), .stop(stop), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_duty(wr_duty), .wr_freq(wr_freq), .wr_dwell(wr_dwell),
        .period_done(period_done), .pwm_en(b_en), .pwm_duty(b_duty), .pwm_freq(b_freq),
        .busy(b_busy), .step_idx(b_step), .seq_done(b_sd), .err(b_err)
    );

    always #5 Clk = ~Clk;

    function automatic vec_t mk(input int rst_n, input int st, input int sp, input int pd,
                                input int we, input int wa, input int wd, input int wf,
                                input int ww, input int sel,
                                input int en, input int duty, input int freq, input int bsy,
                                input int step, input int sd, input int er);
        vec_t v;
        v.rst_n = 1'(rst_n); v.start = 1'(st); v.stop = 1'(sp); v.pd = 1'(pd);
        v.wr_en = 1'(we); v.wr_addr = 2'(wa); v.wr_duty = 4'(wd); v.wr_freq = 2'(wf);
        v.wr_dwell = 8'(ww); v.sel = 1'(sel);
        v.e_en = 1'(en); v.e_duty = 4'(duty); v.e_freq = 2'(freq); v.e_busy = 1'(bsy);
        v.e_step = 2'(step); v.e_sd = 1'(sd); v.e_err = 1'(er);
        return v;
    endfunction

    task automatic chk(input int idx, input string field, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL vec%0d %s: got %0d expected %0d", idx, field, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        int en, duty, freq, bsy, step, sd, er;
        Rst = v.rst_n; start = v.start; stop = v.stop; period_done = v.pd;
        wr_en = v.wr_en; wr_addr = v.wr_addr; wr_duty = v.wr_duty;
        wr_freq = v.wr_freq; wr_dwell = v.wr_dwell;
        @(posedge Clk);
        #1;
        en   = v.sel ? int'(b_en)   : int'(a_en);
        duty = v.sel ? int'(b_duty) : int'(a_duty);
        freq = v.sel ? int'(b_freq) : int'(a_freq);
        bsy  = v.sel ? int'(b_busy) : int'(a_busy);
        step = v.sel ? int'(b_step) : int'(a_step);
        sd   = v.sel ? int'(b_sd)   : int'(a_sd);
        er   = v.sel ? int'(b_err)  : int'(a_err);
        chk(vec_no, "pwm_en",   en,   int'(v.e_en));
        chk(vec_no, "pwm_duty", duty, int'(v.e_duty));
        chk(vec_no, "pwm_freq", freq, int'(v.e_freq));
        chk(vec_no, "busy",     bsy,  int'(v.e_busy));
        chk(vec_no, "step_idx", step, int'(v.e_step));
        chk(vec_no, "seq_done", sd,   int'(v.e_sd));
        chk(vec_no, "err",      er,   int'(v.e_err));
        vec_no++;
    endtask

    initial begin
        Clk = 1'b0; Rst = 1'b0; start = 1'b0; stop = 1'b0; period_done = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_duty = '0; wr_freq = '0; wr_dwell = '0;

        // Reset values on both instances
        vecs.push_back(mk(0,0,0,0, 0,0,0,0,0, 0,  0,0,1,0,0,0,0));
        vecs.push_back(mk(0,0,0,0, 0,0,0,0,0, 1,  0,0,1,0,0,0,0));
        // Two-entry run, LOOP=0: duty 2 for 3 periods, duty 6 for 1, then done
        vecs.push_back(mk(1,0,0,0, 1,0,2,1,3, 0,  0,0,1,0,0,0,0));
        vecs.push_back(mk(1,0,0,0, 1,1,6,2,1, 0,  0,0,1,0,0,0,0));
        vecs.push_back(mk(1,1,0,0, 0,0,0,0,0, 0,  1,2,1,1,0,0,0));
        vecs.push_back(mk(1,0,0,1, 0,0,0,0,0, 0,  1,2,1,1,0,0,0));
        vecs.push_back(mk(1,0,0,0, 0,0,0,0,0, 0,  1,2,1,1,0,0,0));
        vecs.push_back(mk(1,0,0,1, 0,0,0,0,0, 0,  1,2,1,1,0,0,0));
        vecs.push_back(mk(1,0,0,1, 0,0,0,0,0, 0,  1,6,2,1,1,0,0));
        vecs.push_back(mk(1,0,0,1, 0,0,0,0,0, 0,  0,6,2,0,1,1,0));
        vecs.push_back(mk(1,0,0,0, 0,0,0,0,0, 0,  0,6,2,0,1,0,0));
        // Illegal write then start on an empty table; stop in IDLE ignored
        vecs.push_back(mk(0,0,0,0, 0,0,0,0,0, 0,  0,0,1,0,0,0,0));
        vecs.push_back(mk(1,0,0,0, 1,0,5,0,4, 0,  0,0,1,0,0,0,1));
        vecs.push_back(mk(1,1,0,0, 0,0,0,0,0, 0,  0,0,1,0,0,0,1));
        vecs.push_back(mk(1,0,1,1, 0,0,0,0,0, 0,  0,0,1,0,0,0,0));
        // LOOP=1, four entries of dwell 1 (last one written as 0)
        vecs.push_back(mk(0,0,0,0, 0,0,0,0,0, 1,  0,0,1,0,0,0,0));
        vecs.push_back(mk(1,0,0,0, 1,0,1,1,1, 1,  0,0,1,0,0,0,0));
        vecs.push_back(mk(1,0,0,0, 1,1,3,2,1, 1,  0,0,1,0,0,0,0));
        vecs.push_back(mk(1,0,0,0, 1,2,5,3,1, 1,  0,0,1,0,0,0,0));
        vecs.push_back(mk(1,0,0,0, 1,3,7,1,0, 1,  0,0,1,0,0,0,0));
        vecs.push_back(mk(1,1,0,0, 0,0,0,0,0, 1,  1,1,1,1,0,0,0));
        vecs.push_back(mk(1,0,0,1, 0,0,0,0,0, 1,  1,3,2,1,1,0,0));
        vecs.push_back(mk(1,0,0,1, 0,0,0,0,0, 1,  1,5,3,1,2,0,0));
        vecs.push_back(mk(1,0,0,1, 0,0,0,0,0, 1,  1,7,1,1,3,0,0));
        vecs.push_back(mk(1,0,0,1, 0,0,0,0,0, 1,  1,1,1,1,0,0,0));
        vecs.push_back(mk(1,0,0,1, 0,0,0,0,0, 1,  1,3,2,1,1,0,0));
        vecs.push_back(mk(1,1,0,0, 0,0,0,0,0, 1,  1,3,2,1,1,0,0));

        foreach (vecs[i]) apply(vecs[i]);

        // Stop mid-entry (dwell_cnt=2): drains to the next period, no seq_done
        apply(mk(0,0,0,0, 0,0,0,0,0, 0,  0,0,1,0,0,0,0));
        apply(mk(1,0,0,0, 1,0,4,2,3, 0,  0,0,1,0,0,0,0));
        apply(mk(1,1,0,0, 0,0,0,0,0, 0,  1,4,2,1,0,0,0));
        apply(mk(1,0,0,1, 0,0,0,0,0, 0,  1,4,2,1,0,0,0));
        apply(mk(1,0,1,0, 0,0,0,0,0, 0,  1,4,2,1,0,0,0));
        for (int k = 0; k < 3; k++)
            apply(mk(1,1,1,0, 0,0,0,0,0, 0,  1,4,2,1,0,0,0));
        apply(mk(1,0,0,1, 0,0,0,0,0, 0,  0,4,2,0,0,0,0));
        apply(mk(1,0,0,0, 0,0,0,0,0, 0,  0,4,2,0,0,0,0));
        // Stop coincident with period_done
        apply(mk(1,1,0,0, 0,0,0,0,0, 0,  1,4,2,1,0,0,0));
        apply(mk(1,0,1,1, 0,0,0,0,0, 0,  0,4,2,0,0,0,0));

        // Write entry 1 during the period_done that advances to it: old data applies
        apply(mk(0,0,0,0, 0,0,0,0,0, 0,  0,0,1,0,0,0,0));
        apply(mk(1,0,0,0, 1,0,1,1,1, 0,  0,0,1,0,0,0,0));
        apply(mk(1,0,0,0, 1,1,2,2,1, 0,  0,0,1,0,0,0,0));
        apply(mk(1,1,0,0, 0,0,0,0,0, 0,  1,1,1,1,0,0,0));
        apply(mk(1,0,0,1, 1,1,9,3,5, 0,  1,2,2,1,1,0,0));
        apply(mk(1,0,0,1, 0,0,0,0,0, 0,  0,2,2,0,1,1,0));
        apply(mk(1,1,0,0, 0,0,0,0,0, 0,  1,1,1,1,0,0,0));
        apply(mk(1,0,0,1, 0,0,0,0,0, 0,  1,9,3,1,1,0,0));
        apply(mk(1,0,0,1, 0,0,0,0,0, 0,  1,9,3,1,1,0,0));

        // Reset while running, then start without rewriting the table
        apply(mk(0,0,0,0, 0,0,0,0,0, 0,  0,0,1,0,0,0,0));
        apply(mk(1,1,0,0, 0,0,0,0,0, 0,  0,0,1,0,0,0,1));
        apply(mk(1,0,0,0, 0,0,0,0,0, 0,  0,0,1,0,0,0,0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
